// File: rtl/store_access_sequencer.sv
// Store-stage to word-memory sequencer: aligns byte/half/word stores into lane-positioned
// word writes, splitting misaligned SH/SW into two back-to-back writes.
module store_access_sequencer #(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int STORE_OP_WIDTH   = 2,
  parameter logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = STORE_OP_WIDTH'(0),
  parameter logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = STORE_OP_WIDTH'(1),
  parameter logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = STORE_OP_WIDTH'(2)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic [STORE_OP_WIDTH-1:0] req_op,
  input  logic [31:0]               req_data,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wmask,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [1:0] {IDLE, WR0, WR1, RESP} state_t;

  state_t      state, state_nxt;
  logic        split_q, err_q;
  logic [31:0] hi_data;
  logic [3:0]  hi_mask;

  logic [1:0]  off;
  logic [3:0]  size_mask;
  logic [31:0] data_m;
  logic        op_ok, split, reject, accept;
  logic [63:0] lane_vec;
  logic [7:0]  mask_vec;

  // Request decode: only consumed on the accept handshake.
  always_comb begin
    off       = req_addr[1:0];
    size_mask = 4'b0000;
    data_m    = 32'h0;
    op_ok     = 1'b1;
    case (req_op)
      STORE_OP_SB: begin size_mask = 4'b0001; data_m = {24'h0, req_data[7:0]};  end
      STORE_OP_SH: begin size_mask = 4'b0011; data_m = {16'h0, req_data[15:0]}; end
      STORE_OP_SW: begin size_mask = 4'b1111; data_m = req_data;                end
      default:     op_ok = 1'b0;
    endcase
    lane_vec = {32'h0, data_m} << {off, 3'b000};
    mask_vec = {4'b0000, size_mask} << off;
    split    = ((req_op == STORE_OP_SH) && (off == 2'd3)) ||
               ((req_op == STORE_OP_SW) && (off != 2'd0));
    reject   = !op_ok || (split && !ALLOW_MISALIGNED);
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = reject ? RESP : WR0;
      end
      WR0: begin
        mem_valid = 1'b1;
        if (mem_ready) state_nxt = split_q ? WR1 : RESP;
      end
      WR1: begin
        mem_valid = 1'b1;
        if (mem_ready) state_nxt = RESP;
      end
      RESP: begin
        req_ready = 1'b1;
        done      = 1'b1;
        err       = err_q;
        if (req_valid) state_nxt = reject ? RESP : WR0;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side registers only move on accept or on the WR0 handshake, so they hold under stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      split_q   <= 1'b0;
      err_q     <= 1'b0;
      hi_data   <= 32'h0;
      hi_mask   <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wmask <= 4'b0000;
    end else if (accept) begin
      err_q   <= reject;
      split_q <= split && !reject;
      if (!reject) begin
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= lane_vec[31:0];
        mem_wmask <= mask_vec[3:0];
        hi_data   <= lane_vec[63:32];
        hi_mask   <= mask_vec[7:4];
      end
    end else if (state == WR0 && mem_ready && split_q) begin
      mem_addr  <= mem_addr + 32'd4;
      mem_wdata <= hi_data;
      mem_wmask <= hi_mask;
    end
  end

endmodule

// File: tb/tb_store_access_sequencer.sv
// Scoreboard bench for store_access_sequencer: a byte-wise model pushes expected writes
// and responses on issue; a negedge monitor pops and compares on each handshake/done.
module tb_store_access_sequencer;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_data = 32'h0;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        done, err;

  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [31:0] s_req_addr = 32'h0;
  logic [1:0]  s_req_op = 2'd0;
  logic [31:0] s_req_data = 32'h0;
  logic        s_mem_valid;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_wmask;
  logic        s_done, s_err;

  int nvec = 0;
  int nmis = 0;
  wr_t  exp_wr[$];
  bit   exp_err[$];

  always #5 clk = ~clk;

  store_access_sequencer #(.ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .done(done), .err(err)
  );

  store_access_sequencer #(.ALLOW_MISALIGNED(1'b0)) u_dut_strict (
    .clk(clk), .resetn(resetn),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_addr(s_req_addr),
    .req_op(s_req_op), .req_data(s_req_data),
    .mem_valid(s_mem_valid), .mem_ready(1'b1), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_wmask(s_mem_wmask), .done(s_done), .err(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: place each byte individually into its lane.
  task automatic model_push(input logic [31:0] a, input logic [1:0] op, input logic [31:0] d);
    int  nb;
    int  lane;
    wr_t w0, w1;
    case (op)
      2'd0: nb = 1;
      2'd1: nb = 2;
      2'd2: nb = 4;
      default: nb = 0;
    endcase
    if (nb == 0) begin
      exp_err.push_back(1'b1);
      return;
    end
    w0 = '0;
    w1 = '0;
    w0.a = {a[31:2], 2'b00};
    w1.a = w0.a + 32'd4;
    for (int i = 0; i < nb; i++) begin
      lane = int'(a[1:0]) + i;
      if (lane < 4) begin
        w0.d[8*lane +: 8] = d[8*i +: 8];
        w0.m[lane] = 1'b1;
      end else begin
        w1.d[8*(lane-4) +: 8] = d[8*i +: 8];
        w1.m[lane-4] = 1'b1;
      end
    end
    exp_wr.push_back(w0);
    if (w1.m != 4'b0) exp_wr.push_back(w1);
    exp_err.push_back(1'b0);
  endtask

  // Returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [1:0] op, input logic [31:0] d);
    bit ok;
    model_push(a, op, d);
    req_addr  = a;
    req_op    = op;
    req_data  = d;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
  endtask

  always @(negedge clk) begin : monitor
    wr_t w;
    if (resetn) begin
      if (mem_valid) chk("wmask_nonzero", {31'b0, mem_wmask != 4'b0}, 32'd1);
      if (mem_valid && mem_ready) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", mem_addr, w.a);
          chk("wr_data", mem_wdata, w.d);
          chk("wr_mask", {28'b0, mem_wmask}, {28'b0, w.m});
        end
      end
      if (err && !done) chk("err_without_done", 32'd1, 32'd0);
      if (done) begin
        if (exp_err.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else chk("resp_err", {31'b0, err}, {31'b0, exp_err.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rop;
    // reset values
    #12;
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wmask", {28'b0, mem_wmask}, 32'h0);
    chk("rst_done",      {31'b0, done}, 32'd0);
    chk("rst_err",       {31'b0, err}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // SB at lane 3, timing N+1 valid / N+2 done
    issue(32'h0000_1003, 2'd0, 32'hAABB_CCDD);
    @(negedge clk);
    chk("sb_valid_n1", {31'b0, mem_valid}, 32'd1);
    chk("sb_wdata",    mem_wdata, 32'hDD00_0000);
    chk("sb_wmask",    {28'b0, mem_wmask}, 32'h8);
    @(negedge clk);
    chk("sb_done_n2",  {31'b0, done}, 32'd1);
    @(posedge clk); #1;

    // SH then SW accepted in the RESP cycle
    issue(32'h0000_2002, 2'd1, 32'h1234_ABCD);
    @(negedge clk);
    @(posedge clk); #1;
    chk("b2b_in_resp", {31'b0, done & req_ready}, 32'd1);
    issue(32'h0000_2000, 2'd2, 32'hCAFE_F00D);
    @(negedge clk);
    chk("b2b_sw_wdata", mem_wdata, 32'hCAFE_F00D);
    @(posedge clk); #1;

    // split SW with no bubble; split SH wrapping at top of address space
    issue(32'h0000_3001, 2'd2, 32'h1122_3344);
    @(negedge clk);
    @(negedge clk);
    chk("split_wr1_addr",  mem_addr, 32'h0000_3004);
    chk("split_wr1_valid", {31'b0, mem_valid}, 32'd1);
    chk("split_no_done",   {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    issue(32'hFFFF_FFFF, 2'd1, 32'h0000_BEEF);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_addr",  mem_addr, 32'h0000_0000);
    chk("wrap_wdata", mem_wdata, 32'h0000_00BE);
    repeat (2) @(posedge clk); #1;

    // stall 5 cycles in WR0 of a split SW
    mem_ready = 1'b0;
    issue(32'h0000_4003, 2'd2, 32'hA1B2_C3D4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, mem_valid}, 32'd1);
      chk("stall_addr",  mem_addr, 32'h0000_4000);
      chk("stall_wdata", mem_wdata, 32'hD400_0000);
      chk("stall_wmask", {28'b0, mem_wmask}, 32'h8);
      chk("stall_done",  {31'b0, done}, 32'd0);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_wr1_follows", mem_addr, 32'h0000_4004);
    chk("stall_wr1_nodone",  {31'b0, done}, 32'd0);
    @(negedge clk);
    chk("stall_done_after", {31'b0, done}, 32'd1);
    @(posedge clk); #1;

    // strict instance rejects misaligned SW without memory access
    s_req_addr = 32'h0000_3002; s_req_op = 2'd2; s_req_data = 32'h5566_7788;
    s_req_valid = 1'b1;
    chk("strict_ready", {31'b0, s_req_ready}, 32'd1);
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    @(negedge clk);
    chk("strict_done", {31'b0, s_done}, 32'd1);
    chk("strict_err",  {31'b0, s_err}, 32'd1);
    chk("strict_no_mem", {31'b0, s_mem_valid}, 32'd0);
    @(negedge clk);
    chk("strict_idle", {31'b0, s_done | s_mem_valid}, 32'd0);

    // invalid op on the main instance
    @(posedge clk); #1;
    issue(32'h0000_6000, 2'd3, 32'h0);
    @(negedge clk);
    chk("badop_done_n1", {31'b0, done & err}, 32'd1);
    chk("badop_no_mem",  {31'b0, mem_valid}, 32'd0);
    @(posedge clk); #1;

    // reset during WR1 with mem_ready low
    issue(32'h0000_5001, 2'd2, 32'h0102_0304);
    @(negedge clk);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_pre_wr1", mem_addr, 32'h0000_5004);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_async_addr",  mem_addr, 32'h0);
    chk("rst_async_ready", {31'b0, req_ready}, 32'd1);
    void'(exp_wr.pop_front());
    void'(exp_err.pop_front());
    @(negedge clk);
    resetn = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_done", {31'b0, done}, 32'd0);
    end
    @(posedge clk); #1;
    issue(32'h0000_7002, 2'd0, 32'h0000_0077);

    // random mix, back-to-back where possible
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      issue($urandom, rop, $urandom);
    end

    for (int k = 0; k < 200; k++) begin
      if (exp_wr.size() == 0 && exp_err.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("drain_writes", exp_wr.size(), 32'd0);
    chk("drain_resps",  exp_err.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/store_access_sequencer.md
# store_access_sequencer

Sequencer that sits between the multicycle core's store stage and the word-wide data memory port. It accepts one store request (byte address, STORE_OP_* code, raw register data) and drives the memory with word-aligned addresses, lane-positioned write data and byte masks. Misaligned SH/SW stores are split into two back-to-back word writes. Completion and errors are reported to the core's control FSM.

## Interface
Parameters:
- ALLOW_MISALIGNED, default 1: 1 = split misaligned stores into two writes; 0 = reject them with err and no memory access.

Ports:
- clk  input  1  core clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- req_valid  input  1  store request present
- req_ready  output  1  sequencer idle, accepts request this cycle
- req_addr  input  32  byte address
- req_op  input  `STORE_OP_WIDTH  STORE_OP_SB/SH/SW code from riscv_defines.vh
- req_data  input  32  rs2 value, LSB-justified
- mem_valid  output  1  write request to memory
- mem_ready  input  1  memory accepts write this cycle
- mem_addr  output  32  word-aligned address, bits [1:0] always 0
- mem_wdata  output  32  lane-positioned write data
- mem_wmask  output  4  byte-lane enables
- done  output  1  one-cycle pulse, request finished
- err  output  1  one-cycle pulse coincident with done, request rejected

## Operation
- States: IDLE, WR0, WR1, RESP.
- IDLE: req_ready=1. On req_valid, latch addr/op/data; off=addr[1:0].
  - Size mask: SB=4'b0001, SH=4'b0011, SW=4'b1111. Data masked to 8/16/32 bits; unused lanes are 0, never X.
  - 64-bit lane vector = {32'b0, masked data} << 8*off; 8-bit mask vector = {4'b0, size mask} << off.
  - split = (SH and off==3) or (SW and off!=0).
  - Invalid op, or split with ALLOW_MISALIGNED=0 -> RESP with err set; no memory access.
  - Otherwise -> WR0.
- WR0: mem_valid=1, mem_addr={addr[31:2],2'b00}, mem_wdata=vector[31:0], mem_wmask=maskvec[3:0]. On mem_ready: -> WR1 if split, else -> RESP.
- WR1: mem_valid=1, mem_addr=word address+4 (32-bit wrap: 0xFFFFFFFC+4 = 0x00000000), mem_wdata=vector[63:32], mem_wmask=maskvec[7:4]. On mem_ready -> RESP.
- RESP: done=1, err as latched. req_ready=1 so a new request is accepted in this cycle, giving back-to-back operation. From RESP: -> WR0 or RESP if a request is accepted, else -> IDLE.
- mem_wmask is never 0 while mem_valid=1.

## Timing
- All outputs are registered or decoded from state only; no combinational path from req_* or mem_ready to any output.
- Reset: state=IDLE, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wmask=0, done=0, err=0, req_ready=1.
- Aligned store: accept at cycle N, mem_valid from N+1. If mem_ready in N+1, done at N+2. Minimum 2 cycles accept-to-done.
- Split store: minimum 3 cycles. WR1 follows the WR0 handshake directly with no bubble.
- Rejected request: done+err in cycle N+1.
- While mem_valid=1 and mem_ready=0, mem_addr/mem_wdata/mem_wmask hold stable. mem_ready is ignored when mem_valid=0.
- req_* are sampled only at the accept handshake; later changes have no effect.
- resetn asserted mid-transfer (WR0/WR1): immediate return to IDLE with reset output values. A pending second half is dropped, and the core FSM is reset by the same resetn.

## Test plan
- SB addr=0x1003, data=0xAABBCCDD -> one write: addr 0x1000, wdata 0xDD000000, wmask 1000; done at 2 cycles with mem_ready tied 1.
- SH addr=0x2002, data=0x1234ABCD -> addr 0x2000, wdata 0xABCD0000, wmask 1100. Then SW addr=0x2000, data=0xCAFEF00D, accepted in the RESP cycle -> wdata 0xCAFEF00D, wmask 1111.
- SW addr=0x3001, data=0x11223344 -> first write: addr 0x3000, wdata 0x22334400, wmask 1110; second write: addr 0x3004, wdata 0x00000011, wmask 0001; single done, err=0.
- SH addr=0xFFFFFFFF, data=0xBEEF -> first write: addr 0xFFFFFFFC, wdata 0xEF000000, wmask 1000; second write: addr 0x00000000, wdata 0x000000BE, wmask 0001.
- mem_ready held low 5 cycles during WR0 of a split SW -> outputs stable throughout, WR1 follows the handshake, done only after the second handshake. Repeat with ALLOW_MISALIGNED=0 and SW addr=0x3002 -> no mem_valid, done+err at N+1.
- resetn pulsed low while in WR1 with mem_ready=0 -> mem_valid drops asynchronously; after release req_ready=1, no done pulse, and the next request proceeds normally.
